// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory-side bus controller: FSM states and transfer direction.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADDR   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic RD = 1'b1;
   localparam logic WR = 1'b0;

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM: synchronous write, registered read, no reset on contents or read register.
module sp_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: latches addresses from the multiplexed CPU bus, runs RAM
// reads/writes with programmable wait states, and returns read data with ready/bus_oe.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ALE,
   input  logic              En,
   input  logic              Rw,
   input  logic [DATA_W-1:0] bus_in,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   output logic              ready,
   output logic              err
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] ram_rdata;
   logic [3:0]        wcnt, wcnt_nxt, wcnt_inc;
   logic              op_q;
   logic              start;
   logic              bad;
   logic              addr_lat;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      addr_lat  = ALE && (state != ACCESS);
      acc_addr  = ALE ? ADDR_W'(bus_in) : addr_q;
      // A write with ALE high has only the address on the bus; it waits for the next En.
      start     = En && ((state == IDLE && ALE) || state == ADDR) && !(ALE && Rw == WR);
      bad       = En && !ALE && (state == IDLE || state == ACCESS);
      wcnt_inc  = wcnt + 4'd1;
      wcnt_nxt  = wcnt;
      state_nxt = state;

      case (state)
         IDLE: begin
            if (start)     state_nxt = (WS == 4'd0) ? DONE : ACCESS;
            else if (ALE)  state_nxt = ADDR;
         end
         ADDR: begin
            if (start)     state_nxt = (WS == 4'd0) ? DONE : ACCESS;
         end
         ACCESS: begin
            if (wcnt_inc == WS) begin
               state_nxt = DONE;
               wcnt_nxt  = 4'd0;
            end else begin
               wcnt_nxt  = wcnt_inc;
            end
         end
         DONE: begin
            state_nxt = ALE ? ADDR : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         addr_q <= '0;
         wcnt   <= '0;
         op_q   <= WR;
         hold_q <= '0;
         err    <= 1'b0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (addr_lat) addr_q <= ADDR_W'(bus_in);
         if (start)    op_q   <= Rw;
         if (bus_oe)   hold_q <= ram_rdata;
         if (bad)      err    <= 1'b1;
      end
   end

   sp_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (start && Rw == WR),
      .re    (start && Rw == RD),
      .addr  (acc_addr),
      .wdata (bus_in),
      .rdata (ram_rdata)
   );

   // The RAM read register already holds the data in DONE; hold_q keeps it afterwards.
   assign ready   = (state == DONE);
   assign bus_oe  = ready && (op_q == RD);
   assign bus_out = bus_oe ? ram_rdata : hold_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one instance with no wait states, one with three.
module tb_mem_bus_ctrl;
   import mem_bus_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       ALE, En, Rw;
   logic [7:0] bus_in;
   logic [7:0] bo0, bo3;
   logic       oe0, oe3, rdy0, rdy3, err0, err3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_bus_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .ALE(ALE), .En(En), .Rw(Rw), .bus_in(bus_in),
      .bus_out(bo0), .bus_oe(oe0), .ready(rdy0), .err(err0)
   );

   mem_bus_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(3)) dut3 (
      .clk(clk), .rst(rst), .ALE(ALE), .En(En), .Rw(Rw), .bus_in(bus_in),
      .bus_out(bo3), .bus_oe(oe3), .ready(rdy3), .err(err3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply one bus cycle; returns at the following negedge, after the posedge consumed it.
   task automatic step(input logic a, input logic e, input logic r, input logic [7:0] b);
      ALE = a; En = e; Rw = r; bus_in = b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      rst = 1'b0; ALE = 1'b0; En = 1'b0; Rw = 1'b0; bus_in = 8'h00;
      @(negedge clk);
      check("rst_state",   32'(dut0.state), 32'(IDLE));
      check("rst_bus_out", 32'(bo0), 32'h00);
      check("rst_bus_oe",  32'(oe0), 32'h0);
      check("rst_ready",   32'(rdy0), 32'h0);
      check("rst_err",     32'(err0), 32'h0);
      rst = 1'b1;
      idle(2);

      // Write 3C <= A5, ready one cycle after En
      step(1'b1, 1'b0, 1'b0, 8'h3C);
      step(1'b0, 1'b1, 1'b0, 8'hA5);
      check("wr_ready",  32'(rdy0), 32'h1);
      check("wr_bus_oe", 32'(oe0), 32'h0);
      idle(1);
      check("wr_ready_pulse", 32'(rdy0), 32'h0);
      idle(4);

      // Read 3C
      step(1'b1, 1'b0, 1'b0, 8'h3C);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      check("rd_data",   32'(bo0), 32'hA5);
      check("rd_bus_oe", 32'(oe0), 32'h1);
      check("rd_ready",  32'(rdy0), 32'h1);
      idle(1);
      check("rd_oe_drop", 32'(oe0), 32'h0);
      check("rd_hold",    32'(bo0), 32'hA5);
      idle(4);

      // Write 10 <= 5A, then read it on the three-wait-state instance
      step(1'b1, 1'b0, 1'b0, 8'h10);
      step(1'b0, 1'b1, 1'b0, 8'h5A);
      idle(5);
      step(1'b1, 1'b0, 1'b0, 8'h10);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      for (int i = 1; i <= 3; i++) begin
         check($sformatf("ws3_ready_c%0d", i), 32'(rdy3), 32'h0);
         check($sformatf("ws3_oe_c%0d", i),    32'(oe3), 32'h0);
         check($sformatf("ws3_hold_c%0d", i),  32'(bo3), 32'hA5);
         idle(1);
      end
      check("ws3_ready_c4", 32'(rdy3), 32'h1);
      check("ws3_oe_c4",    32'(oe3), 32'h1);
      check("ws3_data_c4",  32'(bo3), 32'h5A);
      idle(2);

      // ALE+En read: address from the bus, addr_q updated too
      check("pre_addr_q", 32'(dut0.addr_q), 32'h10);
      step(1'b1, 1'b1, 1'b1, 8'h3C);
      check("aen_rd_data",   32'(bo0), 32'hA5);
      check("aen_rd_oe",     32'(oe0), 32'h1);
      check("aen_rd_addr_q", 32'(dut0.addr_q), 32'h3C);
      idle(4);

      // ALE+En write: data follows on the next En cycle
      step(1'b1, 1'b1, 1'b0, 8'h40);
      check("aen_wr_state", 32'(dut0.state), 32'(ADDR));
      check("aen_wr_ready", 32'(rdy0), 32'h0);
      step(1'b0, 1'b1, 1'b0, 8'h77);
      check("aen_wr_done",  32'(rdy0), 32'h1);
      idle(4);

      // En with no address from IDLE: error, no access
      step(1'b0, 1'b1, 1'b0, 8'hFF);
      check("perr_err",   32'(err0), 32'h1);
      check("perr_ready", 32'(rdy0), 32'h0);
      check("perr_state", 32'(dut0.state), 32'(IDLE));
      idle(1);
      step(1'b1, 1'b0, 1'b0, 8'h40);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      check("perr_ram_kept", 32'(bo0), 32'h77);
      check("perr_sticky",   32'(err0), 32'h1);
      idle(4);

      // Back-to-back: ALE during DONE goes straight to ADDR
      step(1'b1, 1'b0, 1'b0, 8'h3C);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      check("b2b_rd_data", 32'(bo0), 32'hA5);
      step(1'b1, 1'b0, 1'b0, 8'h20);
      check("b2b_state",  32'(dut0.state), 32'(ADDR));
      check("b2b_addr_q", 32'(dut0.addr_q), 32'h20);
      check("b2b_ready",  32'(rdy0), 32'h0);
      step(1'b0, 1'b1, 1'b0, 8'h99);
      check("b2b_wr_done", 32'(rdy0), 32'h1);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 8'h20);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      check("b2b_rd_back", 32'(bo0), 32'h99);
      idle(4);

      // Async reset in the middle of a three-wait-state access
      step(1'b1, 1'b0, 1'b0, 8'h10);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      check("pre_rst_state", 32'(dut3.state), 32'(ACCESS));
      ALE = 1'b0; En = 1'b0; Rw = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst_state",   32'(dut3.state), 32'(IDLE));
      check("arst_ready",   32'(rdy3), 32'h0);
      check("arst_bus_oe",  32'(oe3), 32'h0);
      check("arst_err",     32'(err3), 32'h0);
      check("arst_bus_out", 32'(bo3), 32'h00);
      check("arst_err0",    32'(err0), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      idle(1);

      // RAM contents survive reset
      step(1'b1, 1'b0, 1'b0, 8'h3C);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      check("persist_data", 32'(bo0), 32'hA5);
      check("persist_oe",   32'(oe0), 32'h1);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
